// File: rtl/aes_pkg.sv
// Shared AES constants: forward S-box table, byte type and default state geometry.
package aes_pkg;

    typedef logic [7:0] byte_t;

    localparam int DEF_NO_ROWS = 4;
    localparam int DEF_NO_COLS = 4;

    // FIPS-197 forward S-box, indexed by the input byte value
    localparam byte_t SBOX_TABLE [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic byte_t sbox_lookup(input byte_t b);
        return SBOX_TABLE[b];
    endfunction

endpackage

// File: rtl/aes_sbox_byte.sv
// Single-byte combinational forward S-box lookup.
module aes_sbox_byte
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    assign o_byte = sbox_lookup(i_byte);

endmodule

// File: rtl/aes_sbox.sv
// Registered SubBytes stage: masked bytes are substituted, the rest pass through,
// all with one cycle of latency.
module aes_sbox
    import aes_pkg::*;
#(
    parameter int NO_ROWS = DEF_NO_ROWS,
    parameter int NO_COLS = DEF_NO_COLS
) (
    input  logic                                   aes_clk,
    input  logic                                   resetn,
    input  logic                                   sbox_en,
    input  logic [NO_ROWS-1:0][NO_COLS-1:0][7:0]   sbox_ip_char_matrix,
    input  logic [3:0]                             sbox_ip_char_row_mask,
    input  logic [3:0]                             sbox_ip_char_col_mask,
    output logic                                   sbox_op_char_matrix_valid,
    output logic [NO_ROWS-1:0][NO_COLS-1:0][7:0]   sbox_op_char_matrix
);

    logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] w_sub;
    logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] w_next;
    logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] r_matrix;
    logic                                 r_valid;

    // Mask bits above NO_ROWS/NO_COLS are simply never indexed
    for (genvar i = 0; i < NO_ROWS; i++) begin : g_row
        for (genvar j = 0; j < NO_COLS; j++) begin : g_col
            aes_sbox_byte u_byte (
                .i_byte (sbox_ip_char_matrix[i][j]),
                .o_byte (w_sub[i][j])
            );
            assign w_next[i][j] = (sbox_ip_char_row_mask[i] && sbox_ip_char_col_mask[j])
                                  ? w_sub[i][j] : sbox_ip_char_matrix[i][j];
        end
    end

    // Matrix holds its last value when idle; only valid tracks the enable
    always_ff @(posedge aes_clk or negedge resetn) begin
        if (!resetn) begin
            r_matrix <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= sbox_en;
            if (sbox_en) begin
                r_matrix <= w_next;
            end
        end
    end

    assign sbox_op_char_matrix       = r_matrix;
    assign sbox_op_char_matrix_valid = r_valid;

endmodule

// File: tb/tb_aes_sbox.sv
// Self-checking bench for aes_sbox; reference S-box is derived from GF(2^8)
// inversion plus the affine transform rather than from a table.
module tb_aes_sbox;

    typedef logic [3:0][3:0][7:0] mat_t;

    logic       aes_clk;
    logic       resetn;
    logic       sbox_en;
    mat_t       in_mat;
    logic [3:0] row_mask;
    logic [3:0] col_mask;
    logic       out_valid;
    mat_t       out_mat;

    int   tests;
    int   fails;
    logic [7:0] ref_tab [256];
    mat_t exp_mat;
    logic exp_v;

    aes_sbox #(.NO_ROWS(4), .NO_COLS(4)) dut (
        .aes_clk                   (aes_clk),
        .resetn                    (resetn),
        .sbox_en                   (sbox_en),
        .sbox_ip_char_matrix       (in_mat),
        .sbox_ip_char_row_mask     (row_mask),
        .sbox_ip_char_col_mask     (col_mask),
        .sbox_op_char_matrix_valid (out_valid),
        .sbox_op_char_matrix       (out_mat)
    );

    initial begin
        aes_clk = 1'b0;
        forever #5 aes_clk = ~aes_clk;
    end

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            if (a[7]) a = (a << 1) ^ 8'h1b;
            else      a = a << 1;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int c = 1; c < 256; c++) begin
            if (x != 8'h00 && gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic mat_t model(input mat_t m, input logic [3:0] rm, input logic [3:0] cm);
        mat_t r;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                r[i][j] = (rm[i] && cm[j]) ? ref_tab[m[i][j]] : m[i][j];
        return r;
    endfunction

    function automatic mat_t rand_mat();
        mat_t r;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                r[i][j] = 8'($urandom_range(0, 255));
        return r;
    endfunction

    task automatic chk_mat(input string tag, input mat_t exp);
        tests++;
        assert (out_mat === exp) else begin
            fails++;
            $error("FAIL %s: matrix observed %h expected %h", tag, out_mat, exp);
        end
    endtask

    task automatic chk_valid(input string tag, input logic exp);
        tests++;
        assert (out_valid === exp) else begin
            fails++;
            $error("FAIL %s: valid observed %b expected %b", tag, out_valid, exp);
        end
    endtask

    task automatic chk_byte(input string tag, input int i, input int j, input logic [7:0] exp);
        tests++;
        assert (out_mat[i][j] === exp) else begin
            fails++;
            $error("FAIL %s[%0d][%0d]: observed %h expected %h", tag, i, j, out_mat[i][j], exp);
        end
    endtask

    // Drive one cycle, advance the model, and compare after the edge
    task automatic step(input string tag, input logic en, input mat_t m,
                        input logic [3:0] rm, input logic [3:0] cm);
        sbox_en  = en;
        in_mat   = m;
        row_mask = rm;
        col_mask = cm;
        @(posedge aes_clk);
        #1;
        if (en) exp_mat = model(m, rm, cm);
        exp_v = en;
        chk_mat(tag, exp_mat);
        chk_valid(tag, exp_v);
    endtask

    logic [7:0] kin  [8];
    logic [7:0] kout [8];
    mat_t m;

    initial begin
        tests = 0;
        fails = 0;
        for (int v = 0; v < 256; v++) ref_tab[v] = ref_sbox(8'(v));
        kin  = '{8'h00, 8'h01, 8'h53, 8'hff, 8'h19, 8'ha0, 8'h9a, 8'he9};
        kout = '{8'h63, 8'h7c, 8'hed, 8'h16, 8'hd4, 8'he0, 8'hb8, 8'h1e};

        // Reset asserted while a request with nonzero data is pending
        resetn   = 1'b1;
        sbox_en  = 1'b1;
        in_mat   = {16{8'h5a}};
        row_mask = 4'hf;
        col_mask = 4'hf;
        #1 resetn = 1'b0;
        #1;
        chk_mat("reset_async", '0);
        chk_valid("reset_async", 1'b0);
        repeat (2) @(posedge aes_clk);
        #1;
        chk_mat("reset_held", '0);
        chk_valid("reset_held", 1'b0);
        exp_mat = '0;
        exp_v   = 1'b0;
        sbox_en = 1'b0;
        resetn  = 1'b1;
        step("post_reset_idle", 1'b0, {16{8'h5a}}, 4'hf, 4'hf);

        // Known FIPS-197 values with full masks, single-cycle request
        m = rand_mat();
        for (int k = 0; k < 8; k++) m[k / 4][k % 4] = kin[k];
        step("known", 1'b1, m, 4'hf, 4'hf);
        for (int k = 0; k < 8; k++) chk_byte("known", k / 4, k % 4, kout[k]);
        step("known_drop", 1'b0, m, 4'hf, 4'hf);

        // Partial masks on an all-zero input
        step("partial", 1'b1, '0, 4'b0101, 4'b0011);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                chk_byte("partial", i, j, ((i == 0 || i == 2) && j < 2) ? 8'h63 : 8'h00);
        step("partial_drop", 1'b0, '0, 4'b0101, 4'b0011);

        // Zero masks give a registered copy
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                m[i][j] = 8'(i * 4 + j);
        step("zero_mask", 1'b1, m, 4'h0, 4'h0);
        chk_mat("zero_mask_copy", m);
        step("zero_mask_drop", 1'b0, m, 4'h0, 4'h0);

        // Streaming: new data every cycle with en held high
        step("stream_19", 1'b1, {16{8'h19}}, 4'hf, 4'hf);
        chk_byte("stream_19", 3, 3, 8'hd4);
        step("stream_3d", 1'b1, {16{8'h3d}}, 4'hf, 4'hf);
        chk_byte("stream_3d", 1, 2, 8'h27);

        // Exhaustive sweep through [0][0], then idle must hold the last result
        for (int v = 0; v < 256; v++) begin
            m = rand_mat();
            m[0][0] = 8'(v);
            step("sweep", 1'b1, m, 4'hf, 4'hf);
        end
        chk_byte("sweep_last", 0, 0, 8'h16);
        step("sweep_hold", 1'b0, rand_mat(), 4'hf, 4'hf);
        step("sweep_hold2", 1'b0, rand_mat(), 4'h3, 4'h5);

        // Random enables, data and masks
        for (int n = 0; n < 60; n++)
            step("random", 1'($urandom_range(0, 1)), rand_mat(),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

        // Reset in the middle of a streaming request, then restart
        step("mid_pre", 1'b1, rand_mat(), 4'hf, 4'hf);
        #3 resetn = 1'b0;
        #1;
        exp_mat = '0;
        exp_v   = 1'b0;
        chk_mat("mid_reset", exp_mat);
        chk_valid("mid_reset", exp_v);
        @(negedge aes_clk);
        resetn = 1'b1;
        step("mid_restart", 1'b1, rand_mat(), 4'ha, 4'h6);
        step("mid_restart_drop", 1'b0, rand_mat(), 4'ha, 4'h6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
